// File: rtl/multi_alarm_clock.sv
// -----------------------------------------------------------------------------
// multi_alarm_clock
//
// 24h HH:MM:SS BCD clock. It has an internal second prescaler, NUM_ALARMS
// independently enabled alarm slots, snooze with re-ring, and an automatic
// stop after RING_MIN minute boundaries with no response.
//
// Optional feature macro: HOUR12_EN
//   When defined, the mode_12h input and the PM output are added. Time is
//   still kept and loaded in 24h form; only the hour display changes.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous reset, active low
//   H_in1/H_in0, M_in1/M_in0
//              in   BCD hour/minute used by LD_time and LD_alarm
//   LD_time    in   load the current time (seconds and prescaler are cleared)
//   LD_alarm   in   write alarm slot alarm_sel
//   alarm_sel  in   slot index for LD_alarm
//   AL_ON      in   per-slot alarm enable
//   STOP_al    in   stop a ringing or snoozed alarm
//   SNOOZE     in   snooze a ringing alarm
//   mode_12h   in   12h display select (HOUR12_EN only)
//   Alarm      out  buzzer drive, registered
//   alarm_id   out  slot that caused the current ring or snooze
//   H_out1..S_out0
//              out  BCD time display
//   PM         out  afternoon indicator in 12h mode (HOUR12_EN only)
//
// FSM states:
//   state     | meaning
//   ----------+------------------------------------------------------
//   S_IDLE    | no alarm active; waits for a slot match at a minute boundary
//   S_RINGING | buzzer on; counts minute boundaries toward auto-stop
//   S_SNOOZED | buzzer off; re-rings when H:M reaches the snooze target
// -----------------------------------------------------------------------------
module multi_alarm_clock #(
    parameter int CLK_PER_SEC = 10,
    parameter int NUM_ALARMS  = 4,
    parameter int SNOOZE_MIN  = 5,
    parameter int RING_MIN    = 2,
    localparam int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [3:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic                  LD_time,
    input  logic                  LD_alarm,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [NUM_ALARMS-1:0] AL_ON,
    input  logic                  STOP_al,
    input  logic                  SNOOZE,
`ifdef HOUR12_EN
    input  logic                  mode_12h,
    output logic                  PM,
`endif
    output logic                  Alarm,
    output logic [AW-1:0]         alarm_id,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [3:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [3:0]            S_out1,
    output logic [3:0]            S_out0
);

    localparam int            PW        = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZED = 2'd2
    } state_t;

    // Timekeeping registers
    logic [PW-1:0] r_presc;
    logic [1:0]    r_h1;
    logic [3:0]    r_h0;
    logic [3:0]    r_m1;
    logic [3:0]    r_m0;
    logic [3:0]    r_s1;
    logic [3:0]    r_s0;
    logic          r_mb;

    // Alarm slots, packed as {H1, H0, M1, M0}
    logic [13:0]   r_slot [NUM_ALARMS];

    // FSM
    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_alarm_id;
    logic [AW-1:0] w_alarm_id_nxt;
    logic [5:0]    r_ring_cnt;
    logic [5:0]    w_ring_cnt_nxt;
    logic [4:0]    r_snz_h;
    logic [4:0]    w_snz_h_nxt;
    logic [5:0]    r_snz_m;
    logic [5:0]    w_snz_m_nxt;
    logic          r_alarm;

    // Combinational helpers
    logic          w_tick;
    logic          w_ld_ok;
    logic [13:0]   w_hm_in;
    logic [13:0]   w_cur_hm;
    logic [4:0]    w_cur_h;
    logic [5:0]    w_cur_m;
    logic [6:0]    w_sum_m;
    logic [4:0]    w_tgt_h;
    logic [5:0]    w_tgt_m;
    logic          w_match;
    logic [AW-1:0] w_match_id;
    logic          w_id_on;

    assign w_tick   = (r_presc == PRESC_MAX);
    assign w_hm_in  = {H_in1, H_in0, M_in1, M_in0};
    assign w_cur_hm = {r_h1, r_h0, r_m1, r_m0};

    // A load is accepted only if every digit is legal and hours <= 23.
    assign w_ld_ok = (((H_in1 < 2'd2) && (H_in0 <= 4'd9)) ||
                      ((H_in1 == 2'd2) && (H_in0 <= 4'd3))) &&
                     (M_in1 <= 4'd5) && (M_in0 <= 4'd9);

    // Binary view of the current H:M, used for snooze arithmetic and compare
    assign w_cur_h = (5'(r_h1) * 5'd10) + 5'(r_h0);
    assign w_cur_m = (6'(r_m1) * 6'd10) + 6'(r_m0);

    // Snooze target = current H:M + SNOOZE_MIN, at most one minute wrap
    assign w_sum_m = 7'(w_cur_m) + 7'(SNOOZE_MIN);

    always_comb begin
        w_tgt_m = w_sum_m[5:0];
        w_tgt_h = w_cur_h;
        if (w_sum_m >= 7'd60) begin
            w_tgt_m = 6'(w_sum_m - 7'd60);
            w_tgt_h = (w_cur_h == 5'd23) ? 5'd0 : (w_cur_h + 5'd1);
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler and BCD time. r_mb flags the cycle after the time became
    // HH:MM:00, either through a seconds carry or a time load.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
            r_h1    <= '0;
            r_h0    <= '0;
            r_m1    <= '0;
            r_m0    <= '0;
            r_s1    <= '0;
            r_s0    <= '0;
            r_mb    <= 1'b0;
        end else begin
            r_mb <= 1'b0;
            if (LD_time && w_ld_ok) begin
                r_presc <= '0;
                r_h1    <= H_in1;
                r_h0    <= H_in0;
                r_m1    <= M_in1;
                r_m0    <= M_in0;
                r_s1    <= '0;
                r_s0    <= '0;
                r_mb    <= 1'b1;
            end else if (w_tick) begin
                r_presc <= '0;
                if (r_s0 == 4'd9) begin
                    r_s0 <= '0;
                    if (r_s1 == 4'd5) begin
                        r_s1 <= '0;
                        r_mb <= 1'b1;
                        if (r_m0 == 4'd9) begin
                            r_m0 <= '0;
                            if (r_m1 == 4'd5) begin
                                r_m1 <= '0;
                                if ((r_h1 == 2'd2) && (r_h0 == 4'd3)) begin
                                    r_h1 <= '0;
                                    r_h0 <= '0;
                                end else if (r_h0 == 4'd9) begin
                                    r_h0 <= '0;
                                    r_h1 <= r_h1 + 2'd1;
                                end else begin
                                    r_h0 <= r_h0 + 4'd1;
                                end
                            end else begin
                                r_m1 <= r_m1 + 4'd1;
                            end
                        end else begin
                            r_m0 <= r_m0 + 4'd1;
                        end
                    end else begin
                        r_s1 <= r_s1 + 4'd1;
                    end
                end else begin
                    r_s0 <= r_s0 + 4'd1;
                end
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Alarm slot storage. Indices with no matching slot are simply not
    // written, which drops out-of-range alarm_sel values.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_slot[i] <= '0;
            end
        end else if (LD_alarm && w_ld_ok) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alarm_sel == AW'(i)) begin
                    r_slot[i] <= w_hm_in;
                end
            end
        end
    end

    // Scan from the top down so the lowest matching slot is the one kept.
    always_comb begin
        w_match    = 1'b0;
        w_match_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (AL_ON[i] && (r_slot[i] == w_cur_hm)) begin
                w_match    = 1'b1;
                w_match_id = AW'(i);
            end
        end
    end

    always_comb begin
        w_id_on = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (r_alarm_id == AW'(i)) begin
                w_id_on = AL_ON[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Alarm FSM
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_alarm_id_nxt = r_alarm_id;
        w_ring_cnt_nxt = r_ring_cnt;
        w_snz_h_nxt    = r_snz_h;
        w_snz_m_nxt    = r_snz_m;
        case (r_state)
            S_IDLE: begin
                if (r_mb && w_match) begin
                    w_state_nxt    = S_RINGING;
                    w_alarm_id_nxt = w_match_id;
                    w_ring_cnt_nxt = '0;
                end
            end
            S_RINGING: begin
                if (STOP_al || !w_id_on) begin
                    w_state_nxt    = S_IDLE;
                    w_ring_cnt_nxt = '0;
                end else if (SNOOZE) begin
                    w_state_nxt = S_SNOOZED;
                    w_snz_h_nxt = w_tgt_h;
                    w_snz_m_nxt = w_tgt_m;
                end else if (r_mb) begin
                    if ((r_ring_cnt + 6'd1) >= 6'(RING_MIN)) begin
                        w_state_nxt    = S_IDLE;
                        w_ring_cnt_nxt = '0;
                    end else begin
                        w_ring_cnt_nxt = r_ring_cnt + 6'd1;
                    end
                end
            end
            S_SNOOZED: begin
                if (STOP_al || !w_id_on) begin
                    w_state_nxt = S_IDLE;
                end else if (r_mb && (w_cur_h == r_snz_h) && (w_cur_m == r_snz_m)) begin
                    w_state_nxt    = S_RINGING;
                    w_ring_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_alarm_id <= '0;
            r_ring_cnt <= '0;
            r_snz_h    <= '0;
            r_snz_m    <= '0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_alarm_id <= w_alarm_id_nxt;
            r_ring_cnt <= w_ring_cnt_nxt;
            r_snz_h    <= w_snz_h_nxt;
            r_snz_m    <= w_snz_m_nxt;
            r_alarm    <= (w_state_nxt == S_RINGING);
        end
    end

    assign Alarm    = r_alarm;
    assign alarm_id = r_alarm_id;
    assign M_out1   = r_m1;
    assign M_out0   = r_m0;
    assign S_out1   = r_s1;
    assign S_out0   = r_s0;

    // -------------------------------------------------------------------------
    // Hour display
    // -------------------------------------------------------------------------
`ifdef HOUR12_EN
    logic [4:0] w_hr12;

    always_comb begin
        H_out1 = r_h1;
        H_out0 = r_h0;
        PM     = 1'b0;
        w_hr12 = w_cur_h;
        if (mode_12h) begin
            PM = (w_cur_h >= 5'd12);
            if (w_cur_h == 5'd0) begin
                w_hr12 = 5'd12;
            end else if (w_cur_h > 5'd12) begin
                w_hr12 = w_cur_h - 5'd12;
            end
            if (w_hr12 >= 5'd10) begin
                H_out1 = 2'd1;
                H_out0 = 4'(w_hr12 - 5'd10);
            end else begin
                H_out1 = 2'd0;
                H_out0 = 4'(w_hr12);
            end
        end
    end
`else
    assign H_out1 = r_h1;
    assign H_out0 = r_h0;
`endif

endmodule

// File: tb/tb_multi_alarm_clock.sv
module tb_multi_alarm_clock;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       reset_p;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm;
    logic [1:0] alarm_sel;
    logic [3:0] AL_ON;
    logic       STOP_al, SNOOZE;

    wire        Alarm;
    wire [1:0]  alarm_id;
    wire [1:0]  H_out1;
    wire [3:0]  H_out0, M_out1, M_out0, S_out1, S_out0;
    wire [23:0] w_time;
    assign w_time = {2'b00, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};

    // Second instance, idle inputs, used only to watch the prescaler
    logic       z1 = 1'b0;
    logic [1:0] z2 = 2'd0;
    logic [3:0] z4 = 4'd0;
    wire        p_Alarm;
    wire [1:0]  p_alarm_id;
    wire [1:0]  p_H_out1;
    wire [3:0]  p_H_out0, p_M_out1, p_M_out0, p_S_out1, p_S_out0;

`ifdef HOUR12_EN
    logic mode_12h;
    wire  PM;
    wire  p_PM;
`endif

    multi_alarm_clock #(
        .CLK_PER_SEC(1), .NUM_ALARMS(4), .SNOOZE_MIN(5), .RING_MIN(2)
    ) u_dut (
        .clk(clk), .reset(reset),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .alarm_sel(alarm_sel),
        .AL_ON(AL_ON), .STOP_al(STOP_al), .SNOOZE(SNOOZE),
`ifdef HOUR12_EN
        .mode_12h(mode_12h), .PM(PM),
`endif
        .Alarm(Alarm), .alarm_id(alarm_id),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .S_out1(S_out1), .S_out0(S_out0)
    );

    multi_alarm_clock #(
        .CLK_PER_SEC(3), .NUM_ALARMS(4), .SNOOZE_MIN(5), .RING_MIN(2)
    ) u_dut_p (
        .clk(clk), .reset(reset_p),
        .H_in1(z2), .H_in0(z4), .M_in1(z4), .M_in0(z4),
        .LD_time(z1), .LD_alarm(z1), .alarm_sel(z2),
        .AL_ON(z4), .STOP_al(z1), .SNOOZE(z1),
`ifdef HOUR12_EN
        .mode_12h(z1), .PM(p_PM),
`endif
        .Alarm(p_Alarm), .alarm_id(p_alarm_id),
        .H_out1(p_H_out1), .H_out0(p_H_out0), .M_out1(p_M_out1), .M_out0(p_M_out0),
        .S_out1(p_S_out1), .S_out0(p_S_out0)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_hm(input logic [1:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0);
        H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0;
    endtask

    task automatic ld_time(input logic [1:0] h1, input logic [3:0] h0,
                           input logic [3:0] m1, input logic [3:0] m0);
        set_hm(h1, h0, m1, m0);
        LD_time = 1'b1;
        cyc(1);
        LD_time = 1'b0;
    endtask

    task automatic ld_alarm(input logic [1:0] sel, input logic [1:0] h1, input logic [3:0] h0,
                            input logic [3:0] m1, input logic [3:0] m0);
        set_hm(h1, h0, m1, m0);
        alarm_sel = sel;
        LD_alarm  = 1'b1;
        cyc(1);
        LD_alarm  = 1'b0;
    endtask

    task automatic pulse_stop();
        STOP_al = 1'b1;
        cyc(1);
        STOP_al = 1'b0;
    endtask

    initial begin
        reset = 1'b0; reset_p = 1'b0;
        set_hm(2'd0, 4'd0, 4'd0, 4'd0);
        LD_time = 1'b0; LD_alarm = 1'b0; alarm_sel = 2'd0;
        AL_ON = 4'b0000; STOP_al = 1'b0; SNOOZE = 1'b0;
`ifdef HOUR12_EN
        mode_12h = 1'b0;
`endif
        cyc(2);
        check("rst_time",  32'(w_time),   32'h000000);
        check("rst_alarm", 32'(Alarm),    32'd0);
        check("rst_id",    32'(alarm_id), 32'd0);

        // Counting and prescaler
        reset = 1'b1; reset_p = 1'b1;
        cyc(8);
        check("count8",  32'(w_time),   32'h000008);
        check("presc8",  32'(p_S_out0), 32'd2);
        cyc(1);
        check("presc9",  32'(p_S_out0), 32'd3);

        ld_time(2'd2, 4'd3, 4'd5, 4'd9);
        check("ld2359",  32'(w_time), 32'h235900);
        cyc(59);
        check("t235959", 32'(w_time), 32'h235959);
        cyc(1);
        check("wrap",    32'(w_time), 32'h000000);
        cyc(5);
        check("t000005", 32'(w_time), 32'h000005);
        reset = 1'b0;
        #1;
        check("async_rst", 32'(w_time), 32'h000000);
        reset = 1'b1;

        // Basic ring
        ld_alarm(2'd0, 2'd1, 4'd0, 4'd2, 4'd0);
        AL_ON = 4'b0001;
        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        check("ld1019",   32'(w_time), 32'h101900);
        cyc(60);
        check("t102000",  32'(w_time), 32'h102000);
        check("ring_lat", 32'(Alarm),  32'd0);
        cyc(1);
        check("ring",     32'(Alarm),    32'd1);
        check("ring_id0", 32'(alarm_id), 32'd0);
        pulse_stop();
        check("stop",     32'(Alarm), 32'd0);

        // Priority of lowest slot
        AL_ON = 4'b0000;
        ld_alarm(2'd1, 2'd0, 4'd7, 4'd0, 4'd0);
        ld_alarm(2'd3, 2'd0, 4'd7, 4'd0, 4'd0);
        AL_ON = 4'b1010;
        ld_time(2'd0, 4'd7, 4'd0, 4'd0);
        check("ld0700",   32'(Alarm), 32'd0);
        cyc(1);
        check("prio_on",  32'(Alarm),    32'd1);
        check("prio_id",  32'(alarm_id), 32'd1);
        pulse_stop();

        // Invalid slot loads leave slot 1 at 07:00
        ld_alarm(2'd1, 2'd2, 4'd4, 4'd0, 4'd0);
        ld_alarm(2'd1, 2'd0, 4'd7, 4'd6, 4'hA);
        ld_time(2'd0, 4'd7, 4'd0, 4'd0);
        cyc(1);
        check("inv_slot_on", 32'(Alarm),    32'd1);
        check("inv_slot_id", 32'(alarm_id), 32'd1);
        pulse_stop();

        // Only slot 3 enabled; invalid LD_time is ignored and counting continues
        AL_ON = 4'b1000;
        ld_time(2'd0, 4'd7, 4'd0, 4'd0);
        check("t070000", 32'(w_time), 32'h070000);
        set_hm(2'd2, 4'd5, 4'd0, 4'd0);
        LD_time = 1'b1;
        cyc(1);
        LD_time = 1'b0;
        check("inv_ldtime", 32'(w_time),   32'h070001);
        check("slot3_on",   32'(Alarm),    32'd1);
        check("slot3_id",   32'(alarm_id), 32'd3);
        pulse_stop();

        // LD_time and LD_alarm together
        AL_ON = 4'b0100;
        set_hm(2'd0, 4'd8, 4'd0, 4'd0);
        alarm_sel = 2'd2;
        LD_time = 1'b1; LD_alarm = 1'b1;
        cyc(1);
        LD_time = 1'b0; LD_alarm = 1'b0;
        check("both_time", 32'(w_time), 32'h080000);
        cyc(1);
        check("both_on",   32'(Alarm),    32'd1);
        check("both_id",   32'(alarm_id), 32'd2);
        pulse_stop();

        // Snooze across midnight
        AL_ON = 4'b0000;
        ld_alarm(2'd0, 2'd2, 4'd3, 4'd5, 4'd8);
        AL_ON = 4'b0001;
        ld_time(2'd2, 4'd3, 4'd5, 4'd8);
        cyc(1);
        check("snz_ring", 32'(Alarm), 32'd1);
        SNOOZE = 1'b1;
        cyc(1);
        SNOOZE = 1'b0;
        check("snoozed",  32'(Alarm), 32'd0);
        cyc(298);
        check("t000300",  32'(w_time), 32'h000300);
        check("snz_lat",  32'(Alarm),  32'd0);
        cyc(1);
        check("rering",    32'(Alarm),    32'd1);
        check("rering_id", 32'(alarm_id), 32'd0);
        STOP_al = 1'b1; SNOOZE = 1'b1;
        cyc(1);
        STOP_al = 1'b0; SNOOZE = 1'b0;
        check("stop_snz",  32'(Alarm), 32'd0);
        cyc(299);
        check("t000801",   32'(w_time), 32'h000801);
        check("no_rering", 32'(Alarm),  32'd0);

        // Auto timeout after two minute boundaries
        ld_time(2'd2, 4'd3, 4'd5, 4'd8);
        cyc(1);
        check("to_ring", 32'(Alarm), 32'd1);
        cyc(60);
        check("to_mb1",  32'(Alarm), 32'd1);
        cyc(59);
        check("t000000", 32'(w_time), 32'h000000);
        check("to_mb2",  32'(Alarm),  32'd1);
        cyc(1);
        check("timeout", 32'(Alarm),  32'd0);

        // Enable drop while ringing
        ld_time(2'd2, 4'd3, 4'd5, 4'd8);
        cyc(1);
        check("en_ring", 32'(Alarm), 32'd1);
        AL_ON = 4'b0000;
        cyc(1);
        check("en_drop", 32'(Alarm), 32'd0);

        // Reset while ringing
        AL_ON = 4'b0001;
        ld_time(2'd2, 4'd3, 4'd5, 4'd8);
        cyc(1);
        check("rr_ring", 32'(Alarm), 32'd1);
        reset = 1'b0;
        #1;
        check("rr_alarm", 32'(Alarm),  32'd0);
        check("rr_time",  32'(w_time), 32'h000000);
        reset = 1'b1;

`ifdef HOUR12_EN
        mode_12h = 1'b1;
        ld_time(2'd0, 4'd0, 4'd3, 4'd0);
        check("h12_00", 32'({H_out1, H_out0}), 32'h12);
        check("pm_00",  32'(PM), 32'd0);
        ld_time(2'd1, 4'd3, 4'd0, 4'd5);
        check("h12_13", 32'({H_out1, H_out0}), 32'h01);
        check("pm_13",  32'(PM), 32'd1);
        mode_12h = 1'b0;
        #1;
        check("h24_13", 32'({H_out1, H_out0}), 32'h13);
        check("pm_24",  32'(PM), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
Parametrised successor to the team's single-alarm BCD clock (Aclock). It keeps the same HH:MM:SS BCD timekeeping and load/stop interface. It adds an internal second prescaler, NUM_ALARMS independently enabled alarm slots, snooze with re-ring, and an auto-timeout on ringing. It sits between the board clock and the display/buzzer logic.

Parameters:
CLK_PER_SEC, 10, clk cycles per second tick (>=1)
NUM_ALARMS, 4, number of alarm slots (1..16)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_MIN, 2, minute boundaries an unanswered alarm rings before auto-stop (1..59)
AW, derived = max(1, clog2(NUM_ALARMS)), not overridable

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
H_in1  in  2  BCD hour tens for load
H_in0  in  4  BCD hour units
M_in1  in  4  BCD minute tens
M_in0  in  4  BCD minute units
LD_time  in  1  load current time from H/M inputs
LD_alarm  in  1  load alarm slot alarm_sel from H/M inputs
alarm_sel  in  AW  alarm slot index for LD_alarm
AL_ON  in  NUM_ALARMS  per-slot alarm enable
STOP_al  in  1  stop ringing/snoozed alarm
SNOOZE  in  1  snooze ringing alarm
Alarm  out  1  buzzer drive, registered
alarm_id  out  AW  slot that caused current ring/snooze
H_out1  out  2  BCD hour tens
H_out0  out  4  BCD hour units
M_out1  out  4  BCD minute tens
M_out0  out  4  BCD minute units
S_out1  out  4  BCD second tens
S_out0  out  4  BCD second units

Behaviour:
- Reset, asynchronous while reset=0: time 00:00:00, prescaler 0, all alarm slots 00:00, state IDLE, Alarm=0, alarm_id=0, ring counter 0. Reset mid-ring drops Alarm immediately.
- Prescaler: counts 0..CLK_PER_SEC-1. The wrap cycle is the sec tick. CLK_PER_SEC=1 means every cycle ticks.
- Tick increments seconds 00-59. The 59->00 carry increments minutes 00-59, which carry into hours 00-23. 23:59:59 -> 00:00:00. All digits stay valid BCD.
- LD_time: loads H:M, sets seconds=00 and prescaler=0. It overrides a tick in the same cycle.
- LD_alarm: writes slot alarm_sel. alarm_sel >= NUM_ALARMS is ignored.
- Any load with an invalid value (digit>9, hours>23, M_in1>5) is ignored entirely.
- LD_time and LD_alarm in the same cycle: both take effect.
- Minute boundary (MB): any cycle where the registered time becomes SS=00, by tick carry or by LD_time.
- Match: on the cycle after an MB, if state is IDLE and some i has AL_ON[i]=1 and slot i == current H:M, the lowest such i wins.
  - Result: state RINGING, alarm_id=i, Alarm=1, ring counter=0.
  - Alarm therefore rises 1 clk after the outputs show HH:MM:00.
- States:
  - IDLE: Alarm=0. Transitions only via Match.
  - RINGING: Alarm=1.
    - STOP_al -> IDLE.
    - SNOOZE -> SNOOZED, snooze target = current H:M + SNOOZE_MIN mod 24h.
    - AL_ON[alarm_id]=0 -> IDLE.
    - Each later MB increments the ring counter. Reaching RING_MIN -> IDLE.
  - SNOOZED: Alarm=0.
    - At MB, if H:M == target -> RINGING, same alarm_id, ring counter=0.
    - STOP_al or AL_ON[alarm_id]=0 -> IDLE.
- Priority when simultaneous: STOP_al > AL_ON drop > SNOOZE > timeout/re-ring.
- Matches of other slots while RINGING/SNOOZED are ignored and not queued.
- LD_time while RINGING does not stop the alarm. Loading a slot does not affect an active ring.
- All state changes are registered, 1 clk after the cause.

Optional Feature:
HOUR12_EN:
- Defined: adds input mode_12h (1) and output PM (1). Timekeeping and loads stay 24h internally.
- With mode_12h=1: H_out displays 12,01..11,12,01..11, and PM=1 for internal hours 12-23.
- With mode_12h=0: 24h display, PM=0. PM resets to 0.
- Undefined: ports absent, 24h display only.

Test Plan:
- Reset/count: CLK_PER_SEC=1, release reset, LD_time 23:59 -> after 59 ticks shows 23:59:59, next tick 00:00:00; reset=0 mid-count -> outputs 00:00:00 immediately.
- Basic ring: AL_ON=0001, slot0=10:20, LD_time 10:19 -> at 10:20:00 Alarm=1 next clk, alarm_id=0; STOP_al -> Alarm=0 next clk.
- Priority/invalid: slots 1 and 3 both 07:00, AL_ON=1010 -> alarm_id=1. LD_alarm 24:00 or 07:6A -> slot unchanged.
- Snooze: ring at 23:58, SNOOZE -> Alarm=0; re-ring at 00:03:00 (wrap); STOP_al with SNOOZE in same cycle -> IDLE.
- Timeout/enable drop: RING_MIN=2, no response -> Alarm=0 at second MB after ring; separately AL_ON[id] cleared while ringing -> Alarm=0 next clk.
- HOUR12_EN: mode_12h=1, time 00:30 -> H_out=12, PM=0; 13:05 -> H_out=01, PM=1.
